// File: rtl/gate_equiv_checker_if.sv
// Bundle between the equivalence checker and the pair of implementations under test.
interface gate_equiv_checker_if #(
    parameter int WIDTH = 2,
    parameter int OUT_W = 6,
    parameter int CNT_W = 16
);
    logic             start;
    logic [WIDTH-1:0] stim;
    logic [OUT_W-1:0] res_a;
    logic [OUT_W-1:0] res_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic             first_fail_valid;
    logic [WIDTH-1:0] first_fail_vec;
    logic [OUT_W-1:0] first_fail_diff;

    // Environment side: issues start and returns both implementation results.
    modport master (
        output start, res_a, res_b,
        input  stim, busy, done, pass, err_count,
               first_fail_valid, first_fail_vec, first_fail_diff
    );

    modport slave (
        input  start, res_a, res_b,
        output stim, busy, done, pass, err_count,
               first_fail_valid, first_fail_vec, first_fail_diff
    );
endinterface

// File: rtl/gate_equiv_checker.sv
// Exhaustive equivalence checker: walks every stimulus vector, compares the
// results of two implementations, counts mismatches and captures the first one.
module gate_equiv_checker #(
    parameter int WIDTH  = 2,
    parameter int OUT_W  = 6,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    gate_equiv_checker_if.slave bus
);
    localparam int HW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [HW-1:0]    hold;
    logic [OUT_W-1:0] diff;
    logic             mis;

    // Per-bit case inequality so X/Z on either side reads as a differing bit.
    always_comb begin
        diff = '0;
        for (int i = 0; i < OUT_W; i++)
            diff[i] = (bus.res_a[i] !== bus.res_b[i]);
        mis = |diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            hold                 <= '0;
            bus.stim             <= '0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.pass             <= 1'b0;
            bus.err_count        <= '0;
            bus.first_fail_valid <= 1'b0;
            bus.first_fail_vec   <= '0;
            bus.first_fail_diff  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state                <= RUN;
                        hold                 <= '0;
                        bus.stim             <= '0;
                        bus.busy             <= 1'b1;
                        bus.done             <= 1'b0;
                        bus.pass             <= 1'b0;
                        bus.err_count        <= '0;
                        bus.first_fail_valid <= 1'b0;
                        bus.first_fail_vec   <= '0;
                        bus.first_fail_diff  <= '0;
                    end
                end
                RUN: begin
                    if (hold == HOLD_LAST) begin
                        hold <= '0;
                        if (mis) begin
                            if (bus.err_count != '1)
                                bus.err_count <= bus.err_count + 1'b1;
                            if (!bus.first_fail_valid) begin
                                bus.first_fail_valid <= 1'b1;
                                bus.first_fail_vec   <= bus.stim;
                                bus.first_fail_diff  <= diff;
                            end
                        end
                        // Last vector ends the run; stim never wraps.
                        if (bus.stim == '1) begin
                            state    <= DONE;
                            bus.busy <= 1'b0;
                            bus.done <= 1'b1;
                            bus.pass <= (bus.err_count == '0) && !mis;
                        end else begin
                            bus.stim <= bus.stim + 1'b1;
                        end
                    end else begin
                        hold <= hold + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_equiv_checker.sv
// Directed bench for gate_equiv_checker: three parameterisations share clk/rst.
module tb_gate_equiv_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic mode0 = 1'b0;
    logic inv1  = 1'b0;
    logic inj2  = 1'b0;

    gate_equiv_checker_if #(.WIDTH(2), .OUT_W(6), .CNT_W(16)) if0 ();
    gate_equiv_checker_if #(.WIDTH(3), .OUT_W(6), .CNT_W(2))  if1 ();
    gate_equiv_checker_if #(.WIDTH(2), .OUT_W(6), .CNT_W(16)) if2 ();

    gate_equiv_checker #(.WIDTH(2), .OUT_W(6), .SETTLE(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(if0));
    gate_equiv_checker #(.WIDTH(3), .OUT_W(6), .SETTLE(1), .CNT_W(2))  u1 (.clk(clk), .rst(rst), .bus(if1));
    gate_equiv_checker #(.WIDTH(2), .OUT_W(6), .SETTLE(3), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic logic [5:0] f(input logic [3:0] s);
        return {s[2] ^ s[1], s[0], ~s[1:0], s[0] ^ s[1], 1'b1};
    endfunction

    assign if0.res_a = f(4'(if0.stim));
    assign if0.res_b = if0.res_a ^ ((mode0 && if0.stim == 2'd2) ? 6'h01 : 6'h00);
    assign if1.res_a = f(4'(if1.stim));
    assign if1.res_b = inv1 ? ~if1.res_a : if1.res_a;
    assign if2.res_a = f(4'(if2.stim));
    assign if2.res_b = if2.res_a ^ {5'b0, inj2};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit         st;
        bit         md;
        logic [1:0] stim;
        bit         busy;
        bit         done;
        bit         pass;
        int         err;
        bit         ffv;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Equal run, then a run with bit0 flipped on vector 2 restarted from DONE.
        tbl[0] = '{1, 0, 2'd0, 1, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 2'd1, 1, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 2'd2, 1, 0, 0, 0, 0};
        tbl[3] = '{0, 0, 2'd3, 1, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 2'd3, 0, 1, 1, 0, 0};
        tbl[5] = '{1, 1, 2'd0, 1, 0, 0, 0, 0};
        tbl[6] = '{0, 1, 2'd1, 1, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 2'd2, 1, 0, 0, 0, 0};
        tbl[8] = '{0, 1, 2'd3, 1, 0, 0, 1, 1};
        tbl[9] = '{0, 1, 2'd3, 0, 1, 0, 1, 1};

        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;

        tick();
        tick();
        chk("rst_stim", 32'(if0.stim), 0);
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_done", 32'(if0.done), 0);
        chk("rst_pass", 32'(if0.pass), 0);
        chk("rst_err", 32'(if0.err_count), 0);
        chk("rst_ffv", 32'(if0.first_fail_valid), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            mode0 = tbl[i].md;
            if (tbl[i].st) if0.start = 1'b1;
            tick();
            if0.start = 1'b0;
            chk($sformatf("v%0d_stim", i), 32'(if0.stim), 32'(tbl[i].stim));
            chk($sformatf("v%0d_busy", i), 32'(if0.busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d_done", i), 32'(if0.done), 32'(tbl[i].done));
            chk($sformatf("v%0d_pass", i), 32'(if0.pass), 32'(tbl[i].pass));
            chk($sformatf("v%0d_err", i), 32'(if0.err_count), 32'(tbl[i].err));
            chk($sformatf("v%0d_ffv", i), 32'(if0.first_fail_valid), 32'(tbl[i].ffv));
        end
        chk("t2_ffvec", 32'(if0.first_fail_vec), 2);
        chk("t2_ffdiff", 32'(if0.first_fail_diff), 32'h01);

        // Restart from DONE after a failing run clears results on the same edge.
        mode0 = 1'b0;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("t6b_busy", 32'(if0.busy), 1);
        chk("t6b_stim", 32'(if0.stim), 0);
        chk("t6b_done", 32'(if0.done), 0);
        chk("t6b_pass", 32'(if0.pass), 0);
        chk("t6b_err", 32'(if0.err_count), 0);
        chk("t6b_ffv", 32'(if0.first_fail_valid), 0);
        repeat (4) tick();
        chk("t6b_end_done", 32'(if0.done), 1);
        chk("t6b_end_pass", 32'(if0.pass), 1);

        // start re-pulsed while busy is ignored.
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        tick();
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("t6a_c3_stim", 32'(if0.stim), 2);
        chk("t6a_c3_busy", 32'(if0.busy), 1);
        tick();
        chk("t6a_c4_stim", 32'(if0.stim), 3);
        tick();
        chk("t6a_c5_done", 32'(if0.done), 1);
        chk("t6a_c5_busy", 32'(if0.busy), 0);

        // Mid-run reset, then simultaneous rst+start, then a clean run.
        mode0 = 1'b1;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_stim", 32'(if0.stim), 0);
        chk("t5_busy", 32'(if0.busy), 0);
        chk("t5_done", 32'(if0.done), 0);
        chk("t5_err", 32'(if0.err_count), 0);
        chk("t5_ffv", 32'(if0.first_fail_valid), 0);
        rst = 1'b1;
        if0.start = 1'b1;
        tick();
        rst = 1'b0;
        if0.start = 1'b0;
        chk("t5_rs_busy", 32'(if0.busy), 0);
        tick();
        chk("t5_rs_idle", 32'(if0.busy), 0);
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("t5_run_stim", 32'(if0.stim), 0);
        chk("t5_run_busy", 32'(if0.busy), 1);
        repeat (4) tick();
        chk("t5_run_done", 32'(if0.done), 1);
        chk("t5_run_err", 32'(if0.err_count), 1);
        chk("t5_run_ffvec", 32'(if0.first_fail_vec), 2);
        mode0 = 1'b0;

        // Every vector differs: 2-bit counter saturates at 3.
        inv1 = 1'b1;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t3_c%0d_busy", c), 32'(if1.busy), 1);
            chk($sformatf("t3_c%0d_stim", c), 32'(if1.stim), 32'(c - 1));
            if (c == 4) chk("t3_c4_err", 32'(if1.err_count), 3);
            tick();
        end
        chk("t3_done", 32'(if1.done), 1);
        chk("t3_err", 32'(if1.err_count), 3);
        chk("t3_pass", 32'(if1.pass), 0);
        chk("t3_ffv", 32'(if1.first_fail_valid), 1);
        chk("t3_ffvec", 32'(if1.first_fail_vec), 0);
        chk("t3_ffdiff", 32'(if1.first_fail_diff), 32'h3f);
        inv1 = 1'b0;

        // SETTLE=3: glitch on early hold cycles of vector 1 is not counted.
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            inj2 = (c == 4 || c == 5);
            chk($sformatf("t4_c%0d_stim", c), 32'(if2.stim), 32'((c - 1) / 3));
            chk($sformatf("t4_c%0d_busy", c), 32'(if2.busy), 1);
            tick();
        end
        inj2 = 1'b0;
        chk("t4_done", 32'(if2.done), 1);
        chk("t4_err", 32'(if2.err_count), 0);
        chk("t4_pass", 32'(if2.pass), 1);

        // Same, but mismatch present on the compare cycle of vector 1.
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            inj2 = (c == 6);
            tick();
        end
        inj2 = 1'b0;
        chk("t4b_done", 32'(if2.done), 1);
        chk("t4b_err", 32'(if2.err_count), 1);
        chk("t4b_ffvec", 32'(if2.first_fail_vec), 1);
        chk("t4b_ffdiff", 32'(if2.first_fail_diff), 32'h01);
        chk("t4b_pass", 32'(if2.pass), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
